// File: rtl/scalar_regfile_sb.sv
// Scalar register file with write-through bypass and a per-register pending-write
// scoreboard used by decode to stall on RAW hazards.
module scalar_regfile_sb #(
  parameter int unsigned DATA_W   = 36,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned MAX_PEND = 3,
  parameter int unsigned ZERO_R0  = 1,
  localparam int unsigned ADDR_W  = $clog2(NUM_REGS),
  localparam int unsigned CNT_W   = $clog2(MAX_PEND + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_valid,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic                     iss_ready,
  output logic                     sb_err,
  output logic                     all_idle
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
  logic              wr_r0;
  logic              iss_r0;
  logic              wr_dec;
  logic              iss_inc;

  assign wr_r0  = (ZERO_R0 != 0) && (wr_addr == '0);
  assign iss_r0 = (ZERO_R0 != 0) && (iss_addr == '0);

  // A writeback only retires a slot when one is actually outstanding.
  assign wr_dec = wr_en && !wr_r0 && (cnt_q[wr_addr] != '0);

  // A retiring writeback on the same register frees its slot for this issue.
  assign iss_ready = iss_r0
                  || (cnt_q[iss_addr] != CNT_W'(MAX_PEND))
                  || (wr_dec && (wr_addr == iss_addr));
  assign iss_inc   = iss_valid && iss_ready && !iss_r0;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    logic sel_wr;
    logic inc;
    logic dec;

    assign sel_wr = wr_en && !wr_r0 && (wr_addr == ADDR_W'(r));
    assign inc    = iss_inc && (iss_addr == ADDR_W'(r));
    assign dec    = wr_dec && (wr_addr == ADDR_W'(r));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        regs_q[r] <= '0;
      end else if (sel_wr) begin
        regs_q[r] <= wr_data;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[r] <= '0;
      end else if (inc && !dec) begin
        cnt_q[r] <= cnt_q[r] + CNT_W'(1);
      end else if (dec && !inc) begin
        cnt_q[r] <= cnt_q[r] - CNT_W'(1);
      end
    end
  end

  // Read ports: r0 forced to zero, then bypass, then storage.
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              a_r0;
    logic              hit;

    assign a    = rd_addr[i*ADDR_W +: ADDR_W];
    assign a_r0 = (ZERO_R0 != 0) && (a == '0);
    assign hit  = wr_en && (wr_addr == a);

    assign rd_data[i*DATA_W +: DATA_W] = a_r0 ? '0 : (hit ? wr_data : regs_q[a]);
    assign rd_busy[i] = !a_r0 && (cnt_q[a] != '0)
                     && !(hit && (cnt_q[a] == CNT_W'(1)));
  end

  always_comb begin
    all_idle = 1'b1;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (cnt_q[r] != '0) all_idle = 1'b0;
    end
  end

  // Sticky until reset: a writeback arrived with nothing outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_err <= 1'b0;
    end else if (wr_en && !wr_r0 && (cnt_q[wr_addr] == '0)) begin
      sb_err <= 1'b1;
    end
  end

endmodule

// File: doc/scalar_regfile_sb.md
# scalar_regfile_sb

Parametrised scalar register file with per-register write scoreboard, sitting in the decode stage between the instruction decoder and the scalar execute/writeback paths. It provides NUM_RD combinational read ports with write-through bypass and one synchronous write port. It tracks outstanding (issued but not yet written back) destinations so decode can stall on RAW hazards. Long-latency units (loads, divides) may have up to MAX_PEND writes in flight to the same register.

## Interface
Parameters:
- DATA_W, 36, register width in bits
- NUM_REGS, 32, number of architectural registers; ADDR_W = $clog2(NUM_REGS)
- NUM_RD, 2, number of read ports (1..4)
- MAX_PEND, 3, maximum outstanding writes per register; CNT_W = $clog2(MAX_PEND+1)
- ZERO_R0, 1, when 1 register 0 reads as zero, ignores writes and is never busy

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses, port i at [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port i source has an outstanding write not satisfied this cycle
- wr_en  in  1  writeback valid
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- iss_valid  in  1  decode issues an instruction writing iss_addr
- iss_addr  in  ADDR_W  issued destination register
- iss_ready  out  1  issue accepted this cycle
- sb_err  out  1  sticky: writeback to a register with zero pending count
- all_idle  out  1  no register has a nonzero pending count

## Operation
- Storage: NUM_REGS x DATA_W flops plus NUM_REGS x CNT_W pending counters.
- Read (combinational), per port i:
  - if ZERO_R0 and addr==0: data 0;
  - else if wr_en and wr_addr==addr: wr_data (bypass);
  - else stored value.
- rd_busy[i] = cnt[addr] != 0, except it is 0 when wr_en, wr_addr==addr and cnt[addr]==1 (the last outstanding write is bypassed). Forced 0 for r0 when ZERO_R0.
- Write: wr_en stores wr_data into wr_addr at the edge. Writes to r0 are dropped when ZERO_R0.
- Scoreboard, per register r, per edge:
  - inc = iss_valid & iss_ready & iss_addr==r
  - dec = wr_en & wr_addr==r & cnt[r]!=0
  - cnt += inc - dec. Simultaneous inc and dec leaves the count unchanged.
- iss_ready = !(cnt[iss_addr]==MAX_PEND and no dec on iss_addr this cycle). A dec to the same register frees the slot in the same cycle.
- Issue to r0 when ZERO_R0: iss_ready=1, count not touched.
- iss_ready is valid independent of iss_valid. Decode must hold iss_valid/iss_addr until iss_ready.
- sb_err sets when wr_en, wr_addr!=r0 (or ZERO_R0=0), and cnt[wr_addr]==0. The data is still written. sb_err clears only on reset.
- all_idle = AND over r of (cnt[r]==0), registered view (current counter state).

## Timing
- Reset (async, rst_n low):
  - all registers 0 and all counters 0;
  - sb_err=0, all_idle=1, iss_ready=1, rd_busy=0, rd_data=0 (for any address, with wr_en low).
- Read latency 0. Write visible via bypass in the same cycle and from storage in the next cycle.
- Issue latency 1: an accepted issue makes rd_busy visible starting the cycle after the edge. A read in the same cycle as the issue does not see it, because the reader is older.
- Writeback clears busy in the same cycle (bypass) when it is the last pending write.
- Reset asserted mid-operation discards all pending counts and data immediately. No writeback is required to drain.
- Multiple read ports addressing the same register return identical data and busy.

## Test plan
- Reset then read: rst_n low with wr_en=0 -> rd_data=0 on all ports, rd_busy=0, all_idle=1, iss_ready=1, sb_err=0.
- Bypass: wr_en=1, wr_addr=5, wr_data=36'h9_ABCD_1234, rd_addr port0=5 same cycle -> rd_data0=36'h9_ABCD_1234. Next cycle with wr_en=0 -> same value from storage.
- RAW stall: issue r7 in cycle 0.
  - cycle 1: read r7 -> rd_busy=1, all_idle=0;
  - cycle 3: wr_en r7 data 36'h1 -> rd_busy=0, rd_data=1;
  - cycle 4: all_idle=1.
- Pending saturation (MAX_PEND=3): issue r3 three times -> iss_ready=0 on the 4th.
  - Same cycle wr_en r3 -> iss_ready=1 and count stays 3.
  - Three further writebacks are needed before rd_busy on r3 drops. The 3rd writeback clears busy in the same cycle.
- r0 handling (ZERO_R0=1): write 36'hF to r0 and issue r0 -> reads 0, rd_busy=0, all_idle stays 1, sb_err stays 0.
- Error and async reset: wr_en to r9 with cnt 0 -> sb_err=1 next cycle and data written. Issue r9, then pulse rst_n low mid-cycle -> sb_err=0, cnt cleared, r9 reads 0 immediately.
